systolic_batch_core: RTL and testbench
======================================

SYSTOLIC_BATCH_CORE -- requirements
Module: systolic_batch_core

Interface
REQ-001 Parameters SHALL be: ARRAY_DIM 8 (array edge); ELEM_BYTES 2 (bytes/element); K_W 20 (inner-dim width); BATCH_W 8 (tile-count width); ADDR_W 64; LEN_W 34.
REQ-002 clock  in  1  sole clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 cmd_valid in 1 / cmd_ready out 1  command handshake.
REQ-005 cmd_act_addr, cmd_wgt_addr, cmd_out_addr  in  ADDR_W  base addresses of tile 0.
REQ-006 cmd_act_stride, cmd_wgt_stride  in  ADDR_W  per-tile address increments.
REQ-007 cmd_inner_dimension  in  K_W  K per tile; cmd_batch_count  in  BATCH_W  tiles per command.
REQ-008 resp_valid out 1 / resp_ready in 1; resp_error out 1; resp_tiles out BATCH_W  completed-tile count.
REQ-009 weights_req_valid out, weights_req_ready in, weights_req_len out LEN_W, weights_req_addr_address out ADDR_W.
REQ-010 activations_req_* and vec_out_req_*  same shape as REQ-009.
REQ-011 sa_start_valid out 1, sa_start_ready in 1, sa_inner_dimension out K_W  array start handshake.
REQ-012 out_beat_valid in 1, out_beat_ready in 1  tap of array-to-writer data handshake.
REQ-013 write_isFlushed  in  1  writer has committed all accepted data.

Function
REQ-014 States SHALL be IDLE, ISSUE, RUN, FLUSH, RESP; cmd_ready=1 only in IDLE.
REQ-015 Command fire SHALL latch all cmd_* fields, clear tile index t and done count.
REQ-016 Fire with inner_dimension==0 or batch_count==0 SHALL go to RESP with resp_error=1, resp_tiles=0, no requests issued.
REQ-017 Otherwise fire SHALL go to ISSUE for t=0.
REQ-018 ISSUE: weights, activations, vec_out req and sa_start valids SHALL assert together; each channel deasserts individually after its own fire; valids need not wait on other readies.
REQ-019 Per-tile values: weights/activations len = ARRAY_DIM*ELEM_BYTES*K; vec_out len = ARRAY_DIM*ARRAY_DIM*ELEM_BYTES; all truncated to LEN_W.
REQ-020 Tile t addresses: act = act_addr + t*act_stride; wgt = wgt_addr + t*wgt_stride; out = out_addr + t*out_len; modulo 2^ADDR_W; stable while valid.
REQ-021 All four channels fired (same or different cycles) SHALL move ISSUE->RUN next cycle.
REQ-022 RUN SHALL count out_beat_valid&&out_beat_ready fires; the ARRAY_DIM-th fire completes tile t and increments resp_tiles.
REQ-023 Beats firing in ISSUE SHALL count toward the current tile; fires in IDLE/FLUSH/RESP ignored.
REQ-024 Tile completion with t<batch_count-1 SHALL go to ISSUE with t+1; else to FLUSH.
REQ-025 FLUSH->RESP on first cycle write_isFlushed=1 (may be immediate).
REQ-026 RESP: resp_valid=1, resp_error=0, resp_tiles=batch_count held stable; resp_ready->IDLE next cycle.
REQ-027 New command SHALL not be accepted same cycle as response fire.
REQ-028 Zero-wait readies SHALL give ISSUE exactly 1 cycle per tile.

Reset
REQ-029 Reset assertion SHALL force IDLE immediately, regardless of state.
REQ-030 Under reset: every valid=0, resp_error=0, resp_tiles=0, lens/addresses=0, cmd_ready=0 until first clock edge after deassertion.
REQ-031 Reset mid-batch SHALL discard progress; no response for the aborted command.

Verification
REQ-032 K=4, batch=1, all ready: req lens 64/64/128, addrs = bases, 8 beats, flushed=1 -> resp_tiles=1, error=0.
REQ-033 batch=3, act_stride=0x100, wgt_stride=0x200, base 0: tile 2 addrs act 0x200, wgt 0x400, out 0x100; resp_tiles=3.
REQ-034 weights_req_ready delayed 5 cycles, others ready: activations/vec_out/sa_start valid drop after 1 cycle, weights holds 6; RUN entered after weights fire.
REQ-035 batch_count=0 -> no req valids, resp_valid next cycle with resp_error=1, resp_tiles=0.
REQ-036 write_isFlushed held 0 for 10 cycles after last beat -> resp_valid stays 0 until flushed=1.
REQ-037 Async reset pulse mid-RUN of tile 1 -> all outputs 0 without clock edge; next command restarts at t=0.

Source files
------------

// File: rtl/systolic_batch_core.sv
// Batched tile sequencer: per tile, issues weight/activation/output requests plus an array start,
// counts result beats, then waits for the writer to flush before responding. Each request channel stalls independently.
module systolic_batch_core #(
  parameter int ARRAY_DIM  = 8,
  parameter int ELEM_BYTES = 2,
  parameter int K_W        = 20,
  parameter int BATCH_W    = 8,
  parameter int ADDR_W     = 64,
  parameter int LEN_W      = 34
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [ADDR_W-1:0]  cmd_act_addr_i,
  input  logic [ADDR_W-1:0]  cmd_wgt_addr_i,
  input  logic [ADDR_W-1:0]  cmd_out_addr_i,
  input  logic [ADDR_W-1:0]  cmd_act_stride_i,
  input  logic [ADDR_W-1:0]  cmd_wgt_stride_i,
  input  logic [K_W-1:0]     cmd_inner_dimension_i,
  input  logic [BATCH_W-1:0] cmd_batch_count_i,
  output logic               resp_valid_o,
  input  logic               resp_ready_i,
  output logic               resp_error_o,
  output logic [BATCH_W-1:0] resp_tiles_o,
  output logic               weights_req_valid_o,
  input  logic               weights_req_ready_i,
  output logic [LEN_W-1:0]   weights_req_len_o,
  output logic [ADDR_W-1:0]  weights_req_addr_address_o,
  output logic               activations_req_valid_o,
  input  logic               activations_req_ready_i,
  output logic [LEN_W-1:0]   activations_req_len_o,
  output logic [ADDR_W-1:0]  activations_req_addr_address_o,
  output logic               vec_out_req_valid_o,
  input  logic               vec_out_req_ready_i,
  output logic [LEN_W-1:0]   vec_out_req_len_o,
  output logic [ADDR_W-1:0]  vec_out_req_addr_address_o,
  output logic               sa_start_valid_o,
  input  logic               sa_start_ready_i,
  output logic [K_W-1:0]     sa_inner_dimension_o,
  input  logic               out_beat_valid_i,
  input  logic               out_beat_ready_i,
  input  logic               write_isFlushed_i
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam int BEAT_W = $clog2(ARRAY_DIM + 2);
  localparam logic [BEAT_W-1:0] BEATS_PER_TILE = BEAT_W'(ARRAY_DIM);
  localparam logic [LEN_W-1:0]  OUT_LEN        = LEN_W'(ARRAY_DIM * ARRAY_DIM * ELEM_BYTES);
  localparam logic [LEN_W-1:0]  ROW_BYTES      = LEN_W'(ARRAY_DIM * ELEM_BYTES);

  logic [2:0]         state_q, state_d;
  logic               init_q;
  logic [3:0]         req_vld_q, req_vld_d;   // {sa_start, vec_out, activations, weights}
  logic [ADDR_W-1:0]  act_cur_q, act_cur_d, wgt_cur_q, wgt_cur_d, out_cur_q, out_cur_d;
  logic [ADDR_W-1:0]  act_stride_q, act_stride_d, wgt_stride_q, wgt_stride_d;
  logic [LEN_W-1:0]   io_len_q, io_len_d, out_len_q, out_len_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [BATCH_W-1:0] batch_q, batch_d, t_q, t_d, done_q, done_d;
  logic               err_q, err_d;
  logic [BEAT_W-1:0]  beat_q, beat_d, beat_sum;
  logic [3:0]         req_rdy;
  logic               beat_fire, last_tile;

  assign req_rdy   = {sa_start_ready_i, vec_out_req_ready_i, activations_req_ready_i, weights_req_ready_i};
  assign beat_fire = out_beat_valid_i && out_beat_ready_i;
  assign beat_sum  = beat_q + {{(BEAT_W-1){1'b0}}, beat_fire};
  assign last_tile = !(((BATCH_W+1)'(t_q) + (BATCH_W+1)'(1)) < (BATCH_W+1)'(batch_q));

  always_comb begin
    state_d      = state_q;
    req_vld_d    = req_vld_q;
    act_cur_d    = act_cur_q;
    wgt_cur_d    = wgt_cur_q;
    out_cur_d    = out_cur_q;
    act_stride_d = act_stride_q;
    wgt_stride_d = wgt_stride_q;
    io_len_d     = io_len_q;
    out_len_d    = out_len_q;
    k_d          = k_q;
    batch_d      = batch_q;
    t_d          = t_q;
    done_d       = done_q;
    err_d        = err_q;
    beat_d       = beat_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i && init_q) begin
          act_cur_d    = cmd_act_addr_i;
          wgt_cur_d    = cmd_wgt_addr_i;
          out_cur_d    = cmd_out_addr_i;
          act_stride_d = cmd_act_stride_i;
          wgt_stride_d = cmd_wgt_stride_i;
          k_d          = cmd_inner_dimension_i;
          batch_d      = cmd_batch_count_i;
          io_len_d     = LEN_W'(cmd_inner_dimension_i) * ROW_BYTES;
          out_len_d    = OUT_LEN;
          t_d          = '0;
          done_d       = '0;
          beat_d       = '0;
          if (cmd_inner_dimension_i == '0 || cmd_batch_count_i == '0) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            err_d     = 1'b0;
            req_vld_d = 4'b1111;
            state_d   = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        req_vld_d = req_vld_q & ~req_rdy;
        // Early beats belong to this tile; saturate so completion is judged in RUN.
        if (beat_fire && beat_q != BEATS_PER_TILE) beat_d = beat_sum;
        if (req_vld_d == 4'b0000) state_d = S_RUN;
      end
      S_RUN: begin
        if (beat_sum >= BEATS_PER_TILE) begin
          done_d = done_q + BATCH_W'(1);
          beat_d = '0;
          if (last_tile) begin
            state_d = S_FLUSH;
          end else begin
            t_d       = t_q + BATCH_W'(1);
            act_cur_d = act_cur_q + act_stride_q;
            wgt_cur_d = wgt_cur_q + wgt_stride_q;
            out_cur_d = out_cur_q + ADDR_W'(out_len_q);
            req_vld_d = 4'b1111;
            state_d   = S_ISSUE;
          end
        end else begin
          beat_d = beat_sum;
        end
      end
      S_FLUSH: if (write_isFlushed_i) state_d = S_RESP;
      S_RESP:  if (resp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      init_q       <= 1'b0;
      req_vld_q    <= '0;
      act_cur_q    <= '0;
      wgt_cur_q    <= '0;
      out_cur_q    <= '0;
      act_stride_q <= '0;
      wgt_stride_q <= '0;
      io_len_q     <= '0;
      out_len_q    <= '0;
      k_q          <= '0;
      batch_q      <= '0;
      t_q          <= '0;
      done_q       <= '0;
      err_q        <= 1'b0;
      beat_q       <= '0;
    end else begin
      state_q      <= state_d;
      init_q       <= 1'b1;
      req_vld_q    <= req_vld_d;
      act_cur_q    <= act_cur_d;
      wgt_cur_q    <= wgt_cur_d;
      out_cur_q    <= out_cur_d;
      act_stride_q <= act_stride_d;
      wgt_stride_q <= wgt_stride_d;
      io_len_q     <= io_len_d;
      out_len_q    <= out_len_d;
      k_q          <= k_d;
      batch_q      <= batch_d;
      t_q          <= t_d;
      done_q       <= done_d;
      err_q        <= err_d;
      beat_q       <= beat_d;
    end
  end

  assign cmd_ready_o                    = (state_q == S_IDLE) && init_q;
  assign resp_valid_o                   = (state_q == S_RESP);
  assign resp_error_o                   = err_q;
  assign resp_tiles_o                   = done_q;
  assign weights_req_valid_o            = req_vld_q[0];
  assign weights_req_len_o              = io_len_q;
  assign weights_req_addr_address_o     = wgt_cur_q;
  assign activations_req_valid_o        = req_vld_q[1];
  assign activations_req_len_o          = io_len_q;
  assign activations_req_addr_address_o = act_cur_q;
  assign vec_out_req_valid_o            = req_vld_q[2];
  assign vec_out_req_len_o              = out_len_q;
  assign vec_out_req_addr_address_o     = out_cur_q;
  assign sa_start_valid_o               = req_vld_q[3];
  assign sa_inner_dimension_o           = k_q;

endmodule

// File: tb/tb_systolic_batch_core.sv
// Directed-plus-random bench: expected addresses, lengths and responses come from plain per-tile arithmetic.
module tb_systolic_batch_core;

  logic        clock, reset;
  logic        cmd_valid, cmd_ready;
  logic [63:0] cmd_act_addr, cmd_wgt_addr, cmd_out_addr, cmd_act_stride, cmd_wgt_stride;
  logic [19:0] cmd_inner_dimension;
  logic [7:0]  cmd_batch_count;
  logic        resp_valid, resp_ready, resp_error;
  logic [7:0]  resp_tiles;
  logic        w_vld, w_rdy, a_vld, a_rdy, o_vld, o_rdy, sa_vld, sa_rdy;
  logic [33:0] w_len, a_len, o_len;
  logic [63:0] w_addr, a_addr, o_addr;
  logic [19:0] sa_k;
  logic        beat_v, beat_r, flushed;

  int checks = 0;
  int errors = 0;

  systolic_batch_core dut (
    .clock_i(clock), .reset_i(reset),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_act_addr_i(cmd_act_addr), .cmd_wgt_addr_i(cmd_wgt_addr), .cmd_out_addr_i(cmd_out_addr),
    .cmd_act_stride_i(cmd_act_stride), .cmd_wgt_stride_i(cmd_wgt_stride),
    .cmd_inner_dimension_i(cmd_inner_dimension), .cmd_batch_count_i(cmd_batch_count),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_error_o(resp_error), .resp_tiles_o(resp_tiles),
    .weights_req_valid_o(w_vld), .weights_req_ready_i(w_rdy), .weights_req_len_o(w_len),
    .weights_req_addr_address_o(w_addr),
    .activations_req_valid_o(a_vld), .activations_req_ready_i(a_rdy), .activations_req_len_o(a_len),
    .activations_req_addr_address_o(a_addr),
    .vec_out_req_valid_o(o_vld), .vec_out_req_ready_i(o_rdy), .vec_out_req_len_o(o_len),
    .vec_out_req_addr_address_o(o_addr),
    .sa_start_valid_o(sa_vld), .sa_start_ready_i(sa_rdy), .sa_inner_dimension_o(sa_k),
    .out_beat_valid_i(beat_v), .out_beat_ready_i(beat_r), .write_isFlushed_i(flushed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_error", resp_error, 0);
    chk("rst_resp_tiles", resp_tiles, 0);
    chk("rst_valids", {w_vld, a_vld, o_vld, sa_vld}, 0);
    chk("rst_lens", {w_len, a_len}, 0);
    chk("rst_out_len", o_len, 0);
    chk("rst_addrs", w_addr | a_addr | o_addr, 0);
    chk("rst_sa_k", sa_k, 0);
  endtask

  task automatic do_reset_pulse();
    #2 reset = 1'b1;
    beat_v = 1'b0; beat_r = 1'b0;
    #1 chk_all_zero();
    @(negedge clock);
    reset = 1'b0;
    #1 chk("rst_rdy_hold", cmd_ready, 0);
    @(negedge clock);
    chk("rst_rdy_after", cmd_ready, 1);
    chk("rst_no_resp", resp_valid, 0);
  endtask

  task automatic finish_resp(input logic [7:0] tiles, input logic err);
    int hold;
    hold = $urandom_range(0, 2);
    for (int i = 0; i <= hold; i++) begin
      chk("resp_valid", resp_valid, 1);
      chk("resp_tiles", resp_tiles, tiles);
      chk("resp_error", resp_error, err);
      chk("resp_cmd_blocked", cmd_ready, 0);
      if (i == hold) resp_ready = 1'b1;
      @(negedge clock);
    end
    resp_ready = 1'b0;
    chk("resp_dropped", resp_valid, 0);
    chk("idle_ready", cmd_ready, 1);
  endtask

  // Starts and ends at a negedge with the DUT idle.
  task automatic do_cmd(input logic [63:0] act, input logic [63:0] wgt, input logic [63:0] outb,
                        input logic [63:0] as, input logic [63:0] ws, input logic [19:0] k,
                        input logic [7:0] b, input int wdelay, input int fdelay,
                        input bit beat_in_issue, input int abort_tile);
    logic [63:0] ea, ew, eo;
    logic [33:0] eio;
    int sent, need, r;
    eio = 34'(k) * 34'd16;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_act_addr = act; cmd_wgt_addr = wgt; cmd_out_addr = outb;
    cmd_act_stride = as; cmd_wgt_stride = ws;
    cmd_inner_dimension = k; cmd_batch_count = b;
    cmd_valid = 1'b1;
    flushed = (fdelay == 0);
    @(negedge clock);
    cmd_valid = 1'b0;
    cmd_act_addr = {$urandom, $urandom}; cmd_wgt_addr = {$urandom, $urandom};
    cmd_act_stride = {$urandom, $urandom}; cmd_inner_dimension = 20'($urandom);
    cmd_batch_count = 8'($urandom);
    if (k == 0 || b == 0) begin
      chk("err_no_reqs", {w_vld, a_vld, o_vld, sa_vld}, 0);
      finish_resp(8'd0, 1'b1);
      return;
    end
    for (int t = 0; t < int'(b); t++) begin
      ea = act + 64'(t) * as;
      ew = wgt + 64'(t) * ws;
      eo = outb + 64'(t) * 64'd128;
      for (int c = 0; c <= wdelay + 1; c++) begin
        chk("wgt_vld", w_vld, c <= wdelay);
        chk("act_vld", a_vld, c == 0);
        chk("out_vld", o_vld, c == 0);
        chk("sa_vld", sa_vld, c == 0);
        if (c <= wdelay) begin
          chk("wgt_addr", w_addr, ew);
          chk("wgt_len", w_len, eio);
        end
        if (c == 0) begin
          chk("act_addr", a_addr, ea);
          chk("act_len", a_len, eio);
          chk("out_addr", o_addr, eo);
          chk("out_len", o_len, 128);
          chk("sa_k", sa_k, k);
          chk("issue_no_cmd", cmd_ready, 0);
        end
        a_rdy = 1'b1; o_rdy = 1'b1; sa_rdy = 1'b1;
        w_rdy = (c >= wdelay);
        beat_v = (c == 0) && beat_in_issue;
        beat_r = beat_v;
        if (c <= wdelay) @(negedge clock);
      end
      w_rdy = 1'b0; a_rdy = 1'b0; o_rdy = 1'b0; sa_rdy = 1'b0;
      need = beat_in_issue ? 7 : 8;
      sent = 0;
      while (sent < need) begin
        chk("tile_pending", sa_vld, 0);
        chk("no_early_resp", resp_valid, 0);
        if (t == abort_tile && sent == 3) begin
          do_reset_pulse();
          return;
        end
        r = $urandom_range(0, 3);
        if (r == 0) begin
          beat_v = 1'($urandom_range(0, 1));
          beat_r = !beat_v;
        end else begin
          beat_v = 1'b1; beat_r = 1'b1;
          sent++;
        end
        @(negedge clock);
      end
      beat_v = 1'b0; beat_r = 1'b0;
    end
    chk("flush_entry", resp_valid, 0);
    for (int i = 0; i < fdelay; i++) begin
      chk("flush_hold", resp_valid, 0);
      @(negedge clock);
    end
    flushed = 1'b1;
    @(negedge clock);
    finish_resp(b, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; resp_ready = 1'b0;
    cmd_act_addr = '0; cmd_wgt_addr = '0; cmd_out_addr = '0;
    cmd_act_stride = '0; cmd_wgt_stride = '0;
    cmd_inner_dimension = '0; cmd_batch_count = '0;
    w_rdy = 1'b0; a_rdy = 1'b0; o_rdy = 1'b0; sa_rdy = 1'b0;
    beat_v = 1'b0; beat_r = 1'b0; flushed = 1'b1;
    repeat (2) @(negedge clock);
    chk_all_zero();
    reset = 1'b0;
    #1 chk("init_rdy_hold", cmd_ready, 0);
    @(negedge clock);

    // Single tile, K=4, everything ready.
    do_cmd(64'h1000, 64'h2000, 64'h3000, 64'h40, 64'h80, 20'd4, 8'd1, 0, 0, 0, -1);
    // Three tiles from base 0 with strides.
    do_cmd(64'h0, 64'h0, 64'h0, 64'h100, 64'h200, 20'd16, 8'd3, 0, 0, 0, -1);
    // Weights ready held off for 5 cycles.
    do_cmd(64'hA000, 64'hB000, 64'hC000, 64'h10, 64'h20, 20'd8, 8'd2, 5, 0, 0, -1);
    // Degenerate commands.
    do_cmd(64'h1, 64'h2, 64'h3, 64'h4, 64'h5, 20'd7, 8'd0, 0, 0, 0, -1);
    do_cmd(64'h1, 64'h2, 64'h3, 64'h4, 64'h5, 20'd0, 8'd2, 0, 0, 0, -1);
    // Slow flush.
    do_cmd(64'h5000, 64'h6000, 64'h7000, 64'h8, 64'h8, 20'd2, 8'd1, 0, 10, 1, -1);
    // Reset during tile 1, then restart from tile 0.
    do_cmd(64'h100, 64'h200, 64'h300, 64'h1000, 64'h2000, 20'd5, 8'd3, 0, 0, 0, 1);
    do_cmd(64'h100, 64'h200, 64'h300, 64'h1000, 64'h2000, 20'd5, 8'd2, 1, 2, 1, -1);
    // Randomized commands, including address wraparound and the maximum K.
    do_cmd({$urandom, $urandom}, 64'hFFFF_FFFF_FFFF_FF00, 64'hFFFF_FFFF_FFFF_FFC0,
           {$urandom, $urandom}, 64'h80, 20'hFFFFF, 8'd3, 0, 1, 0, -1);
    for (int n = 0; n < 5; n++) begin
      do_cmd({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             {$urandom, $urandom}, {$urandom, $urandom}, 20'($urandom_range(1, 1000)),
             8'($urandom_range(1, 4)), $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
